// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, FSM state type and init-pattern helper for regfile_mp.
//   RF_DATA_W_DEF / RF_ADDR_W_DEF / RF_NUM_RD_DEF / RF_INIT_MODE_DEF / RF_DBG_IDX_DEF :
//     default parameter values for the register file.
//   rf_state_e   : initialisation FSM states (RF_INIT, RF_READY).
//   init_pattern : index -> {tens digit, ones digit} read as hex (e.g. 31 -> 8'h31).
package regfile_pkg;

  localparam int unsigned RF_DATA_W_DEF    = 32;
  localparam int unsigned RF_ADDR_W_DEF    = 5;
  localparam int unsigned RF_NUM_RD_DEF    = 2;
  localparam int unsigned RF_INIT_MODE_DEF = 1;
  localparam int unsigned RF_DBG_IDX_DEF   = 10;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Only meaningful for indices 0..99; larger indices keep the low nibble of each digit.
  function automatic logic [7:0] init_pattern(input logic [7:0] idx);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = idx / 8'd10;
    ones = idx % 8'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of regfile_mp.
//   addr      in   read address
//   ready     in   register file initialised; output forced to 0 while low
//   wr_en     in   write enables of the two write ports
//   wr_addr0/1, wr_data0/1 in  write port address/data (used by the bypass only)
//   mem_data  in   stored contents of the addressed register
//   data      out  read data
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data (port 1 wins).
module regfile_rd_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              ready,
  input  logic [1:0]        wr_en,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sel_data;

`ifdef REGFILE_BYPASS_EN
  // Address 0 never matches a stored write, and is masked below anyway.
  always_comb begin
    sel_data = mem_data;
    if (wr_en[1] && (wr_addr1 == addr)) begin
      sel_data = wr_data1;
    end else if (wr_en[0] && (wr_addr0 == addr)) begin
      sel_data = wr_data0;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1};
  assign sel_data  = mem_data;
`endif

  assign data = (!ready || (addr == '0)) ? '0 : sel_data;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, hardwired-zero
// register 0 and a sequenced initialisation engine.
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-high
//   init_req  in   pulse; restarts initialisation when sampled in READY
//   rd_addr   in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   out  packed read data, same packing
//   wr_en     in   write enables, bit p for write port p (port 1 wins on collision)
//   wr_addr0/1, wr_data0/1 in  write addresses / data
//   ready     out  initialisation complete, ports live
//   dbg_data  out  contents of register DBG_IDX (0 while not ready)
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = RF_DATA_W_DEF,
  parameter int unsigned ADDR_W    = RF_ADDR_W_DEF,
  parameter int unsigned NUM_RD    = RF_NUM_RD_DEF,
  parameter int unsigned INIT_MODE = RF_INIT_MODE_DEF,
  parameter int unsigned DBG_IDX   = RF_DBG_IDX_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     init_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [DATA_W-1:0]        wr_data1,
  output logic                     ready,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  LastIdx  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DbgAddr = ADDR_W'(DBG_IDX);

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [7:0]        init_idx;
  logic [DATA_W-1:0] init_val;
  logic [1:0]        wr_live;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = RF_READY;
        end
      end
      RF_READY: begin
        if (init_req) begin
          state_d = RF_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = RF_INIT;
    endcase
  end

  assign ready    = (state_q == RF_READY);
  assign init_idx = 8'(cnt_q[ADDR_W-1:0]);
  assign init_val = (INIT_MODE == 1) ? DATA_W'(init_pattern(init_idx)) : '0;
  // Writes are dropped during INIT; register 0 is never written by the ports.
  assign wr_live  = ready ? wr_en : 2'b00;

  // Storage is not reset; the INIT sequence defines its contents.
  always_ff @(posedge clock) begin
    if (state_q == RF_INIT) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= init_val;
    end else begin
      if (wr_en[0] && (wr_addr0 != '0)) begin
        mem_q[wr_addr0] <= wr_data0;
      end
      // Issued after port 0 so port 1 wins a same-address collision.
      if (wr_en[1] && (wr_addr1 != '0)) begin
        mem_q[wr_addr1] <= wr_data1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .addr     (addr_k),
      .ready    (ready),
      .wr_en    (wr_live),
      .wr_addr0 (wr_addr0),
      .wr_addr1 (wr_addr1),
      .wr_data0 (wr_data0),
      .wr_data1 (wr_data1),
      .mem_data (mem_q[addr_k]),
      .data     (rd_data[k*DATA_W +: DATA_W])
    );
  end

  assign dbg_data = (ready && (DbgAddr != '0)) ? mem_q[DbgAddr] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clock;
  logic        reset;
  logic        init_req;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        ready;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;

  regfile_mp dut (
    .clock    (clock),
    .reset    (reset),
    .init_req (init_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .ready    (ready),
    .dbg_data (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected index pattern: decimal digits of n read as hex.
  function automatic logic [31:0] pat(input int n);
    return 32'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    init_req = 1'b0;
    wr_en    = 2'b00;
    wr_addr0 = '0;
    wr_addr1 = '0;
    wr_data0 = '0;
    wr_data1 = '0;
    rd_addr  = {5'd10, 5'd31};
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rd0", rd_data[31:0], 32'd0);
    check("reset_rd1", rd_data[63:32], 32'd0);
    check("reset_dbg", dbg_data, 32'd0);

    tick();
    tick();
    reset = 1'b0;
    // ready low for edges 1..31, high after edge 32.
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("init_ready_lo_%0d", i), {31'd0, ready}, 32'd0);
    end
    tick();
    check("init_ready_hi", {31'd0, ready}, 32'd1);
    check("init_dbg", dbg_data, 32'h10);
    set_rd(5'd31, 5'd10);
    check("init_rd31", rd_data[31:0], 32'h31);
    check("init_rd10", rd_data[63:32], 32'h10);

    // Port 0 write, read back on port 1 next cycle.
    wr_en = 2'b01; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
    tick();
    wr_en = 2'b00;
    set_rd(5'd0, 5'd5);
    check("wr5_rd1", rd_data[63:32], 32'hDEADBEEF);

    // Register 0 is hardwired.
    wr_en = 2'b01; wr_addr0 = 5'd0; wr_data0 = 32'hFFFFFFFF;
    tick();
    wr_en = 2'b00;
    set_rd(5'd0, 5'd0);
    check("wr0_rd0", rd_data[31:0], 32'd0);
    check("wr0_rd1", rd_data[63:32], 32'd0);

    // Collision: port 1 wins.
    wr_en = 2'b11; wr_addr0 = 5'd7; wr_data0 = 32'hAAAA; wr_addr1 = 5'd7; wr_data1 = 32'h5555;
    tick();
    wr_en = 2'b00;
    set_rd(5'd7, 5'd5);
    check("collide_rd7", rd_data[31:0], 32'h5555);
    check("collide_rd5", rd_data[63:32], 32'hDEADBEEF);

    // Same-cycle write/read of reg 9.
    wr_en = 2'b01; wr_addr0 = 5'd9; wr_data0 = 32'h1234;
    set_rd(5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
    check("samecyc_rd9", rd_data[31:0], 32'h1234);
`else
    check("samecyc_rd9", rd_data[31:0], 32'h9);
`endif
    tick();
    wr_en = 2'b00;
    #1;
    check("after_rd9", rd_data[63:32], 32'h1234);

    // Modify reg 20, then re-initialise; writes during INIT are dropped.
    wr_en = 2'b01; wr_addr0 = 5'd20; wr_data0 = 32'hBAD;
    tick();
    wr_en    = 2'b00;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    wr_en = 2'b01; wr_addr0 = 5'd5; wr_data0 = 32'hCAFE;
    set_rd(5'd5, 5'd20);
    check("reinit_ready_lo", {31'd0, ready}, 32'd0);
    check("reinit_rd_gated", rd_data[31:0], 32'd0);
    check("reinit_dbg_gated", dbg_data, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("reinit_lo_%0d", i), {31'd0, ready}, 32'd0);
    end
    tick();
    wr_en = 2'b00;
    #1;
    check("reinit_ready_hi", {31'd0, ready}, 32'd1);
    check("reinit_rd5", rd_data[31:0], 32'h5);
    check("reinit_rd20", rd_data[63:32], 32'h20);
    set_rd(5'd7, 5'd9);
    check("reinit_rd7", rd_data[31:0], 32'h7);
    check("reinit_rd9", rd_data[63:32], 32'h9);

    // Dirty reg 12 and 31, re-init, then reset at init index 12.
    wr_en = 2'b11; wr_addr0 = 5'd12; wr_data0 = 32'h1111; wr_addr1 = 5'd31; wr_data1 = 32'h2222;
    tick();
    wr_en    = 2'b00;
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    set_rd(5'd12, 5'd31);
    reset = 1'b1;
    #1;
    check("midreset_ready", {31'd0, ready}, 32'd0);
    check("midreset_rd0", rd_data[31:0], 32'd0);
    check("midreset_rd1", rd_data[63:32], 32'd0);
    check("midreset_dbg", dbg_data, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("rerun_lo_%0d", i), {31'd0, ready}, 32'd0);
    end
    tick();
    check("rerun_ready_hi", {31'd0, ready}, 32'd1);
    check("rerun_dbg", dbg_data, 32'h10);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      check($sformatf("pattern_p0_r%0d", i), rd_data[31:0], pat(i));
      check($sformatf("pattern_p1_r%0d", 31 - i), rd_data[63:32], pat(31 - i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
